// File: rtl/mem_stage.sv
// MEM stage: word-addressed data memory, branch resolution for fetch, and the
// MEM/WB boundary register with a sticky misaligned-access flag.
module mem_stage #(
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] AddResultIn,
  input  logic [31:0] ALUResultIn,
  input  logic [4:0]  MuxIn,
  input  logic [31:0] ReadData2In,
  input  logic        ZeroIn,
  input  logic        MemWriteIn,
  input  logic        MemReadIn,
  input  logic        BranchIn,
  input  logic        MemtoRegIn,
  input  logic        RegWriteIn,
  output logic        PCSrc,
  output logic [31:0] BranchTarget,
  output logic [31:0] ReadDataOut,
  output logic [31:0] ALUResultOut,
  output logic [4:0]  MuxOut,
  output logic        MemtoRegOut,
  output logic        RegWriteOut,
  output logic        AlignErr
);

  // MEM/WB boundary bundle
  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        mem_to_reg;
    logic        reg_write;
  } memwb_t;

  // Power-up contents are zero; Reset deliberately leaves memory alone.
  logic [31:0] mem_q [DEPTH] = '{default: '0};

  logic [ADDR_BITS-1:0] word_idx;
  logic                 misaligned;
  logic                 do_store;
  logic                 do_load;
  memwb_t               memwb_d, memwb_q;
  logic                 align_err_d, align_err_q;

  // Branch decision goes straight back to fetch, no state involved
  assign PCSrc        = BranchIn & ZeroIn;
  assign BranchTarget = AddResultIn;

  assign word_idx   = ALUResultIn[ADDR_BITS+1:2];
  assign misaligned = (MemReadIn | MemWriteIn) & (ALUResultIn[1:0] != 2'b00);
  assign do_store   = MemWriteIn & ~misaligned & ~Reset;
  assign do_load    = MemReadIn & ~misaligned;

  always_ff @(posedge Clk) begin
    if (do_store) mem_q[word_idx] <= ReadData2In;
  end

  // Load samples the array before this edge's store lands (read-before-write)
  always_comb begin
    memwb_d            = '0;
    memwb_d.rdata      = do_load ? mem_q[word_idx] : 32'd0;
    memwb_d.alu        = ALUResultIn;
    memwb_d.rd         = MuxIn;
    memwb_d.mem_to_reg = MemtoRegIn;
    memwb_d.reg_write  = RegWriteIn & ~(MemReadIn & misaligned);
    align_err_d        = align_err_q | misaligned;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      memwb_q     <= '0;
      align_err_q <= 1'b0;
    end else begin
      memwb_q     <= memwb_d;
      align_err_q <= align_err_d;
    end
  end

  assign ReadDataOut  = memwb_q.rdata;
  assign ALUResultOut = memwb_q.alu;
  assign MuxOut       = memwb_q.rd;
  assign MemtoRegOut  = memwb_q.mem_to_reg;
  assign RegWriteOut  = memwb_q.reg_write;
  assign AlignErr     = align_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random traffic, all checked
// against an array-based behavioural model of the memory stage.
module tb_mem_stage;
  localparam int DEPTH = 256;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] AddResultIn, ALUResultIn, ReadData2In;
  logic [4:0]  MuxIn;
  logic        ZeroIn, MemWriteIn, MemReadIn, BranchIn, MemtoRegIn, RegWriteIn;
  logic        PCSrc;
  logic [31:0] BranchTarget, ReadDataOut, ALUResultOut;
  logic [4:0]  MuxOut;
  logic        MemtoRegOut, RegWriteOut, AlignErr;

  int checks = 0;
  int errors = 0;

  mem_stage #(.DEPTH(DEPTH), .ADDR_BITS(8)) dut (
    .Clk(Clk), .Reset(Reset), .AddResultIn(AddResultIn), .ALUResultIn(ALUResultIn),
    .MuxIn(MuxIn), .ReadData2In(ReadData2In), .ZeroIn(ZeroIn),
    .MemWriteIn(MemWriteIn), .MemReadIn(MemReadIn), .BranchIn(BranchIn),
    .MemtoRegIn(MemtoRegIn), .RegWriteIn(RegWriteIn), .PCSrc(PCSrc),
    .BranchTarget(BranchTarget), .ReadDataOut(ReadDataOut), .ALUResultOut(ALUResultOut),
    .MuxOut(MuxOut), .MemtoRegOut(MemtoRegOut), .RegWriteOut(RegWriteOut),
    .AlignErr(AlignErr)
  );

  always #5 Clk = ~Clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [DEPTH];
  logic [31:0] e_rdata, e_alu;
  logic [4:0]  e_rd;
  logic        e_m2r, e_rw, e_err;
  logic        chk_en = 1'b0;

  initial for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic logic mis(input logic [31:0] a, input logic rd, input logic wr);
    return (rd || wr) && (a % 4 != 0);
  endfunction

  always @(posedge Clk) begin
    chk_en <= 1'b1;
    if (Reset) begin
      e_rdata <= 0; e_alu <= 0; e_rd <= 0; e_m2r <= 0; e_rw <= 0; e_err <= 0;
    end else begin
      e_rdata <= (MemReadIn && !mis(ALUResultIn, MemReadIn, MemWriteIn))
                 ? m_mem[widx(ALUResultIn)] : 32'd0;
      e_alu   <= ALUResultIn;
      e_rd    <= MuxIn;
      e_m2r   <= MemtoRegIn;
      e_rw    <= RegWriteIn && !(MemReadIn && mis(ALUResultIn, MemReadIn, MemWriteIn));
      e_err   <= e_err || mis(ALUResultIn, MemReadIn, MemWriteIn);
      if (MemWriteIn && !mis(ALUResultIn, MemReadIn, MemWriteIn))
        m_mem[widx(ALUResultIn)] <= ReadData2In;
    end
  end

  // Compare process: inputs change at negedge+1, so at negedge both registered
  // and combinational outputs are stable.
  always @(negedge Clk) begin
    if (chk_en) begin
      checks++;
      if (ReadDataOut !== e_rdata || ALUResultOut !== e_alu || MuxOut !== e_rd ||
          MemtoRegOut !== e_m2r || RegWriteOut !== e_rw || AlignErr !== e_err) begin
        errors++;
        $display("FAIL memwb t=%0t got rd=%h alu=%h mux=%0d m2r=%b rw=%b err=%b want rd=%h alu=%h mux=%0d m2r=%b rw=%b err=%b",
                 $time, ReadDataOut, ALUResultOut, MuxOut, MemtoRegOut, RegWriteOut, AlignErr,
                 e_rdata, e_alu, e_rd, e_m2r, e_rw, e_err);
      end
      checks++;
      if (PCSrc !== (BranchIn & ZeroIn) || BranchTarget !== AddResultIn) begin
        errors++;
        $display("FAIL branch got pcsrc=%b tgt=%h want pcsrc=%b tgt=%h",
                 PCSrc, BranchTarget, BranchIn & ZeroIn, AddResultIn);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic rst, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] dst, input logic rw);
    @(negedge Clk); #1;
    Reset = rst; MemReadIn = rd; MemWriteIn = wr; ALUResultIn = addr;
    ReadData2In = data; MuxIn = dst; RegWriteIn = rw; MemtoRegIn = rd;
    @(posedge Clk); #1;
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  initial begin
    Reset = 1; AddResultIn = 0; ALUResultIn = 0; ReadData2In = 0; MuxIn = 0;
    ZeroIn = 0; MemWriteIn = 0; MemReadIn = 0; BranchIn = 0; MemtoRegIn = 0; RegWriteIn = 0;

    // Reset wins over a store and a register write
    drive(1, 0, 1, 32'h10, 32'hAAAA_5555, 5'd3, 1);
    lit("rst_rw", {31'd0, RegWriteOut}, 0);
    lit("rst_alu", ALUResultOut, 0);
    lit("rst_err", {31'd0, AlignErr}, 0);
    drive(0, 1, 0, 32'h10, 0, 5'd1, 1);
    lit("rst_store_dropped", ReadDataOut, 0);

    // Store then load
    drive(0, 0, 1, 32'h20, 32'hDEAD_BEEF, 5'd0, 0);
    drive(0, 1, 0, 32'h20, 0, 5'd7, 1);
    lit("st_ld_data", ReadDataOut, 32'hDEAD_BEEF);
    lit("st_ld_rw", {31'd0, RegWriteOut}, 1);
    lit("st_ld_mux", {27'd0, MuxOut}, 7);

    // Address wrap
    drive(0, 0, 1, 32'h400, 32'h1234_5678, 5'd0, 0);
    drive(0, 1, 0, 32'h0, 0, 5'd2, 1);
    lit("wrap", ReadDataOut, 32'h1234_5678);

    // Misaligned store / load
    drive(0, 0, 1, 32'h21, 32'hFFFF_FFFF, 5'd0, 0);
    lit("mis_st_err", {31'd0, AlignErr}, 1);
    drive(0, 1, 0, 32'h20, 0, 5'd4, 1);
    lit("mis_st_mem", ReadDataOut, 32'hDEAD_BEEF);
    drive(0, 1, 0, 32'h22, 0, 5'd4, 1);
    lit("mis_ld_rw", {31'd0, RegWriteOut}, 0);
    lit("mis_ld_data", ReadDataOut, 0);
    drive(0, 0, 0, 32'h0, 0, 5'd0, 0);
    lit("err_sticky", {31'd0, AlignErr}, 1);

    // Read-before-write
    drive(0, 0, 1, 32'h30, 32'h11, 5'd0, 0);
    drive(0, 1, 1, 32'h30, 32'h22, 5'd5, 1);
    lit("rbw_old", ReadDataOut, 32'h11);
    drive(0, 1, 0, 32'h30, 0, 5'd5, 1);
    lit("rbw_new", ReadDataOut, 32'h22);

    // Branch is combinational
    @(negedge Clk); #1;
    BranchIn = 1; ZeroIn = 1; AddResultIn = 32'h40; #1;
    lit("br_pcsrc", {31'd0, PCSrc}, 1);
    lit("br_tgt", BranchTarget, 32'h40);
    ZeroIn = 0; #1;
    lit("br_nz", {31'd0, PCSrc}, 0);

    drive(1, 0, 0, 0, 0, 0, 0);
    lit("rst_clr_err", {31'd0, AlignErr}, 0);

    // Random traffic over a small word set so stores and loads collide
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      a = {$urandom_range(0, 3) == 0 ? $urandom() : 32'd0} & 32'hFFFF_FC00;
      a = a | ($urandom_range(0, 7) << 2) | (32'($urandom_range(0, 9) == 0 ? $urandom_range(1, 3) : 0));
      @(negedge Clk); #1;
      BranchIn = 1'($urandom); ZeroIn = 1'($urandom); AddResultIn = $urandom();
      drive_nowait(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom), a,
                   $urandom(), 5'($urandom), 1'($urandom));
      @(posedge Clk);
    end

    @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic drive_nowait(input logic rst, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [4:0] dst, input logic rw);
    Reset = rst; MemReadIn = rd; MemWriteIn = wr; ALUResultIn = addr;
    ReadData2In = data; MuxIn = dst; RegWriteIn = rw; MemtoRegIn = 1'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
